// File: rtl/status_framer.sv
// status_framer: snapshots a command tag and four 24-bit channel values on request and streams them as a frame
// Ports: clk; rst (async, active-low); req/cmd_tag/d_value0..3 snapshot inputs;
//   status_out/status_valid/status_ready word handshake to the PISO stage;
//   busy, frame_done, frame_abort, req_drop status outputs (all registered).
// Define STATUS_FRAMER_CKSUM_EN to append an XOR checksum word after CH3.
module status_framer #(
  parameter logic [7:0] HDR_MARK = 8'hA5,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [7:0]  cmd_tag,
  input  logic [23:0] d_value0,
  input  logic [23:0] d_value1,
  input  logic [23:0] d_value2,
  input  logic [23:0] d_value3,
  output logic [23:0] status_out,
  output logic        status_valid,
  input  logic        status_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        req_drop
);
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, HDR, CH0, CH1, CH2, CH3, CKS} state_t;
`ifdef STATUS_FRAMER_CKSUM_EN
  localparam state_t LAST = CKS;
`else
  localparam state_t LAST = CH3;
`endif
  state_t state, state_n, adv;
  logic [7:0] seq, seq_n, tag;
  logic [23:0] s0, s1, s2, s3, out_n, word, w3;
  logic [SW-1:0] stall, stall_n;
  logic valid_n, done_n, abort_n, drop_n, accept, load, xfer;
  // the frame_done cycle is already IDLE but must still reject req
  assign accept = state == IDLE && !frame_done;
  assign xfer = status_valid && status_ready;
  assign adv = state_t'(state + 3'd1);
`ifdef STATUS_FRAMER_CKSUM_EN
  assign w3 = adv == CH3 ? s3 : {HDR_MARK, tag, seq} ^ s0 ^ s1 ^ s2 ^ s3;
`else
  assign w3 = s3;
`endif
  assign word = adv == CH0 ? s0 : adv == CH1 ? s1 : adv == CH2 ? s2 : w3;
  always_comb begin
    state_n = state;
    out_n = status_out;
    valid_n = status_valid;
    seq_n = seq;
    stall_n = stall;
    done_n = 1'b0;
    abort_n = 1'b0;
    drop_n = req && !accept;
    load = 1'b0;
    if (req && accept) begin
      load = 1'b1;
      state_n = HDR;
      out_n = {HDR_MARK, cmd_tag, seq};
      valid_n = 1'b1;
      stall_n = '0;
    end else if (xfer) begin
      stall_n = '0;
      if (state == LAST) begin
        state_n = IDLE;
        valid_n = 1'b0;
        done_n = 1'b1;
        seq_n = seq + 8'd1;
      end else begin
        state_n = adv;
        out_n = word;
      end
    end else if (status_valid) begin
      // the edge ending the TIMEOUT_CYC-th stalled cycle aborts the frame
      if (stall == SW'(TIMEOUT_CYC - 1)) begin
        state_n = IDLE;
        valid_n = 1'b0;
        abort_n = 1'b1;
        stall_n = '0;
      end else begin
        stall_n = stall + SW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      status_out <= '0;
      status_valid <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
      req_drop <= 1'b0;
      seq <= '0;
      stall <= '0;
      tag <= '0;
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      state <= state_n;
      status_out <= out_n;
      status_valid <= valid_n;
      busy <= state_n != IDLE;
      frame_done <= done_n;
      frame_abort <= abort_n;
      req_drop <= drop_n;
      seq <= seq_n;
      stall <= stall_n;
      if (load) begin
        tag <= cmd_tag;
        s0 <= d_value0;
        s1 <= d_value1;
        s2 <= d_value2;
        s3 <= d_value3;
      end
    end
  end
endmodule

// File: tb/tb_status_framer.sv
// tb_status_framer: scoreboard bench for status_framer (honours STATUS_FRAMER_CKSUM_EN)
module tb_status_framer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0;
  logic status_ready = 1'b0;
  logic [7:0] cmd_tag = '0;
  logic [23:0] d_value0 = '0, d_value1 = '0, d_value2 = '0, d_value3 = '0;
  logic [23:0] status_out;
  logic status_valid, busy, frame_done, frame_abort, req_drop;
  int n_vec = 0, n_err = 0, n_done = 0, n_abort = 0, n_drop = 0, exp_done = 0;
  logic [23:0] sb[$];
  logic [7:0] exp_seq = '0;
  logic pv = 1'b0, pr = 1'b0;
  logic [23:0] po = '0;

  always #5 clk = ~clk;

  status_framer #(.HDR_MARK(8'hA5), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_tag(cmd_tag),
    .d_value0(d_value0), .d_value1(d_value1), .d_value2(d_value2), .d_value3(d_value3),
    .status_out(status_out), .status_valid(status_valid), .status_ready(status_ready),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort), .req_drop(req_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (frame_done) n_done++;
      if (frame_abort) n_abort++;
      if (req_drop) n_drop++;
      check("done_abort_excl", {31'd0, frame_done && frame_abort}, 0);
      if (pv && !pr && !frame_abort) check("hold", {status_valid, status_out}, {1'b1, po});
      if (status_valid && status_ready) begin
        if (sb.size() == 0) check("sb_nonempty", sb.size(), 1);
        else check("word", status_out, sb.pop_front());
      end
      pv = status_valid;
      pr = status_ready;
      po = status_out;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] t, input logic [23:0] a, b, c, d);
    cmd_tag = t;
    d_value0 = a;
    d_value1 = b;
    d_value2 = c;
    d_value3 = d;
    req = 1'b1;
    sb.push_back({8'hA5, t, exp_seq});
    sb.push_back(a);
    sb.push_back(b);
    sb.push_back(c);
    sb.push_back(d);
`ifdef STATUS_FRAMER_CKSUM_EN
    sb.push_back({8'hA5, t, exp_seq} ^ a ^ b ^ c ^ d);
`endif
    exp_seq++;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!(frame_done || frame_abort) && k < 300) begin
      tick();
      k++;
    end
    check(tag, {31'd0, frame_done || frame_abort}, 1);
  endtask

  task automatic finish_frame(input string tag);
    wait_end(tag);
    check({tag, "_sb_empty"}, sb.size(), 0);
    exp_done++;
    tick();
  endtask

  initial begin
    logic [23:0] hdr;
    repeat (3) tick();
    check("rst_out", {status_out, status_valid, busy, frame_done, frame_abort, req_drop}, 0);
    rst = 1'b1;
    status_ready = 1'b1;
    tick();
    // basic frame, d_value0 altered right after capture
    start(8'h3C, 24'h000001, 24'h000002, 24'h000003, 24'h000004);
    check("busy", busy, 1);
    check("hdr_valid", status_valid, 1);
    d_value0 = 24'hFFFFFF;
    finish_frame("f0_end");
    check("f0_done_cnt", n_done, 1);
    // second frame with a 5-cycle stall on CH1
    start(8'h3C, 24'h000001, 24'h000002, 24'h000003, 24'h000004);
    tick();
    tick();
    status_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("ch1_stall", {status_valid, status_out}, {1'b1, 24'h000002});
      tick();
    end
    status_ready = 1'b1;
    finish_frame("f1_end");
    // req during CH2 is dropped; req in the frame_done cycle is dropped too
    start(8'h71, 24'h123456, 24'h89ABCD, 24'hEF0123, 24'h456789);
    repeat (3) tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("drop_ch2", req_drop, 1);
    wait_end("f2_end");
    check("f2_sb_empty", sb.size(), 0);
    exp_done++;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("drop_done", {req_drop, busy, status_valid}, 3'b100);
    tick();
    check("drop_clear", req_drop, 0);
    // timeout abort from HDR with ready low
    status_ready = 1'b0;
    hdr = {8'hA5, 8'h55, exp_seq};
    start(8'h55, 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D);
    for (int i = 0; i < 8; i++) begin
      check("abort_wait", {frame_abort, status_valid, status_out}, {1'b0, 1'b1, hdr});
      tick();
    end
    check("abort", {frame_abort, status_valid, busy}, 3'b100);
    sb.delete();
    exp_seq = exp_seq - 8'd1;
    status_ready = 1'b1;
    tick();
    check("abort_clear", frame_abort, 0);
    start(8'h56, 24'h111111, 24'h222222, 24'h333333, 24'h444444);
    finish_frame("post_abort_end");
    // 256 frames so seq wraps through 255 to 0
    for (int f = 0; f < 256; f++) begin
      start(8'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
      finish_frame("wrap_end");
    end
    // reset mid-frame
    start(8'h99, 24'h000111, 24'h000222, 24'h000333, 24'h000444);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid", {status_out, status_valid, busy, frame_done, frame_abort, req_drop}, 0);
    sb.delete();
    exp_seq = '0;
    tick();
    rst = 1'b1;
    tick();
    start(8'h3C, 24'h000001, 24'h000002, 24'h000003, 24'h000004);
    finish_frame("post_rst_end");
    check("done_total", n_done, exp_done);
    check("abort_total", n_abort, 1);
    check("drop_total", n_drop, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/status_framer.md
STATUS_FRAMER -- requirements
Module: status_framer

Interface
REQ-001 Parameter HDR_MARK, default 8'hA5, header marker byte placed in bits [23:16] of the header word.
REQ-002 Parameter TIMEOUT_CYC, default 1000, consecutive stalled cycles before an in-flight frame is aborted.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  snapshot request from the vehicle processor, sampled each cycle.
REQ-006 cmd_tag  input  8  command tag echoed in header bits [15:8].
REQ-007 d_value0..d_value3  input  24 each  quadrature channel distance/speed values.
REQ-008 status_out  output  24  frame word presented to the PISO stage.
REQ-009 status_valid  output  1  status_out holds a valid word.
REQ-010 status_ready  input  1  PISO stage accepts the word this cycle.
REQ-011 busy  output  1  frame in progress (state not IDLE).
REQ-012 frame_done  output  1  one-cycle pulse after the last word transfers.
REQ-013 frame_abort  output  1  one-cycle pulse on timeout abort.
REQ-014 req_drop  output  1  one-cycle pulse when req is high while not IDLE.

Function
REQ-015 Transfer occurs on a rising edge where status_valid and status_ready are both 1.
REQ-016 States: IDLE, HDR, CH0, CH1, CH2, CH3, CKS (CKS only with the Configuration macro); all outputs registered.
REQ-017 IDLE: on req=1, capture cmd_tag and d_value0..3 into snapshot registers at that edge and enter HDR; status_valid is 1 in the following cycle (one-cycle latency).
REQ-018 HDR word = {HDR_MARK, tag, seq[7:0]}; CHn word = snapshot of d_valuen.
REQ-019 Each state advances to the next on transfer; status_out and status_valid are held unchanged while status_valid=1 and status_ready=0.
REQ-020 After the final word transfers: status_valid=0, frame_done pulses, seq increments modulo 256 (255 wraps to 0), state returns to IDLE.
REQ-021 req is accepted only in IDLE; req in any other state, including the frame_done cycle, pulses req_drop and is otherwise ignored.
REQ-022 Input changes to d_value0..3 or cmd_tag after capture do not affect the frame in flight.
REQ-023 A stall counter counts cycles with status_valid=1 and status_ready=0, clears on every transfer, and is sized for TIMEOUT_CYC.
REQ-024 When the stall counter reaches TIMEOUT_CYC: status_valid=0, frame_abort pulses, state returns to IDLE, and seq is not incremented.
REQ-025 frame_done and frame_abort never assert in the same cycle.

Reset
REQ-026 While rst=0: state IDLE, status_out=0, status_valid=0, busy=0, frame_done=0, frame_abort=0, req_drop=0, seq=0, stall counter=0, snapshot registers=0.
REQ-027 Reset asserted mid-frame aborts immediately without frame_abort; the first req after release produces seq=0.

Configuration
REQ-028 Macro STATUS_FRAMER_CKSUM_EN defined: the frame is 6 words; CKS word = bitwise XOR of HDR and CH0..CH3, sent after CH3.
REQ-029 Macro undefined: the frame is 5 words, CH3 is last, and no checksum logic is present.

Verification
REQ-030 Reset, then req with cmd_tag=8'h3C, d_value0..3=24'h000001/000002/000003/000004, status_ready=1 -> words A53C00, 000001, 000002, 000003, 000004 (plus CKS A53C04 with macro), one per cycle; frame_done pulses once; next frame header seq=01.
REQ-031 status_ready=0 for 5 cycles during CH1 -> status_out=000002 is held stable with valid=1 for all 5 cycles; CH2 follows after ready rises.
REQ-032 d_value0 changes to 24'hFFFFFF one cycle after req -> CH0 still 000001.
REQ-033 req pulsed during CH2 -> req_drop pulses once and the frame completes unchanged.
REQ-034 TIMEOUT_CYC=8, ready held low from HDR -> frame_abort pulses on the 8th stalled cycle, valid drops, and the next frame reuses the same seq.
REQ-035 Run 256 frames -> the 257th header has seq=00; rst pulsed low mid-frame -> all outputs 0 and the next header seq=00.
